// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - requester handshakes and display outputs of the display scheduler
interface display_scheduler_if;
    logic        clear_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_i;
    logic [7:0]  tx_data_i;
    logic        tx_ready_o;
    logic [15:0] data_o;
    logic        src_o;
    logic        busy_o;

    modport master (
        output clear_i, rx_valid_i, rx_data_i, tx_valid_i, tx_data_i,
        input  rx_ready_o, tx_ready_o, data_o, src_o, busy_o
    );

    modport slave (
        input  clear_i, rx_valid_i, rx_data_i, tx_valid_i, tx_data_i,
        output rx_ready_o, tx_ready_o, data_o, src_o, busy_o
    );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin byte scheduler feeding a 16-bit hex display (optional hold: DISPLAY_SCHEDULER_HOLD_EN)
module display_scheduler #(
    parameter int CLKFREQ = 100_000_000,
    parameter int HOLD_MS = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scheduler_if.slave   bus
);
    localparam int HOLD_RAW = CLKFREQ / 1000 * HOLD_MS;
    localparam int HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;

    logic        idle;
    logic        rx_grant;
    logic        tx_grant;
    logic        xfer;
    logic [7:0]  win_byte;
    logic [15:0] data_q, data_d;
    logic        src_q, src_d;
    logic        prio_q, prio_d;

`ifdef DISPLAY_SCHEDULER_HOLD_EN
    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign idle       = (state_q == S_IDLE);
    assign bus.busy_o = (state_q == S_HOLD);

    // FSM state and hold counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a transfer starts a hold, the hold ends after HOLD_CYC cycles, clear aborts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clear_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (xfer) begin
            state_d = S_HOLD;
            cnt_d   = '0;
        end else if (state_q == S_HOLD) begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
`else
    // Without the hold feature the scheduler is permanently idle; timing parameters are inert
    logic unused_hold_cfg;
    assign unused_hold_cfg = (HOLD_CYC > 0);
    assign idle            = 1'b1;
    assign bus.busy_o      = 1'b0;
`endif

    // Round-robin arbitration; readies are suppressed during reset, clear and hold
    always_comb begin
        rx_grant = 1'b0;
        tx_grant = 1'b0;
        if (idle && !rst && !bus.clear_i) begin
            if (bus.rx_valid_i && (!bus.tx_valid_i || !prio_q)) begin
                rx_grant = 1'b1;
            end else if (bus.tx_valid_i) begin
                tx_grant = 1'b1;
            end
        end
    end

    assign xfer           = rx_grant || tx_grant;
    assign win_byte       = tx_grant ? bus.tx_data_i : bus.rx_data_i;
    assign bus.rx_ready_o = rx_grant;
    assign bus.tx_ready_o = tx_grant;
    assign bus.data_o     = data_q;
    assign bus.src_o      = src_q;

    // Display shift register, source flag and round-robin pointer updates
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        prio_d = prio_q;
        if (bus.clear_i) begin
            data_d = 16'h0000;
        end else if (xfer) begin
            data_d = {data_q[7:0], win_byte};
            src_d  = tx_grant;
            prio_d = ~tx_grant;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 16'h0000;
            src_q  <= 1'b0;
            prio_q <= 1'b0;
        end else begin
            data_q <= data_d;
            src_q  <= src_d;
            prio_q <= prio_d;
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
module tb_display_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int          cyc;
        logic        src;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic        pend = 1'b0;
    logic [15:0] m_data = 16'h0000;

    display_scheduler_if bus ();

    display_scheduler #(.CLKFREQ(4000), .HOLD_MS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input int c, input logic s, input logic [7:0] b);
        exp_t e;
        m_data = {m_data[7:0], b};
        e.cyc  = c;
        e.src  = s;
        e.data = m_data;
        sb.push_back(e);
    endtask

    task automatic send(input logic s, input logic [7:0] b);
        if (s) begin
            bus.tx_valid_i = 1'b1;
            bus.tx_data_i  = b;
        end else begin
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = b;
        end
        expect_xfer(cyc, s, b);
        @(negedge clk);
        chk("send_ready", s ? bus.tx_ready_o : bus.rx_ready_o, 1);
        step();
        if (s) bus.tx_valid_i = 1'b0;
        else   bus.rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o && n < 20) begin
            step();
            n++;
        end
        chk("idle_timeout", bus.busy_o, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 20) begin
            step();
            n++;
        end
        step();
        chk("sb_empty", sb.size(), 0);
    endtask

    // Monitor: every observed transfer is matched against the scoreboard
    always @(negedge clk) begin
        if (pend) begin
            chk("data_o", bus.data_o, cur.data);
            chk("src_o", bus.src_o, cur.src);
            pend = 1'b0;
        end
        if ((bus.rx_ready_o && bus.rx_valid_i) || (bus.tx_ready_o && bus.tx_valid_i)) begin
            chk("one_ready", bus.rx_ready_o & bus.tx_ready_o, 0);
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                chk("xfer_cyc", cyc, cur.cyc);
                chk("xfer_src", bus.tx_ready_o, cur.src);
                pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.clear_i    = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h99;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        step();
        @(negedge clk);
        chk("rst_rx_ready", bus.rx_ready_o, 0);
        chk("rst_data", bus.data_o, 16'h0000);
        chk("rst_src", bus.src_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        step();
        bus.rx_valid_i = 1'b0;
        rst            = 1'b0;
        m_data         = 16'h0000;

`ifdef DISPLAY_SCHEDULER_HOLD_EN
        send(1'b0, 8'h41);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s1_busy_hold", bus.busy_o, 1);
        end
        @(negedge clk);
        chk("s1_busy_end", bus.busy_o, 0);
        step();

        rst = 1'b1;
        step();
        rst    = 1'b0;
        m_data = 16'h0000;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h12;
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h34;
        expect_xfer(cyc, 1'b0, 8'h12);
        expect_xfer(cyc + 5, 1'b1, 8'h34);
        @(negedge clk);
        chk("s2_tx_loses", bus.tx_ready_o, 0);
        step();
        bus.rx_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s3_tx_ready_hold", bus.tx_ready_o, 0);
            chk("s3_busy", bus.busy_o, 1);
        end
        @(negedge clk);
        chk("s3_tx_ready_idle", bus.tx_ready_o, 1);
        step();
        bus.tx_valid_i = 1'b0;
        @(negedge clk);
        chk("s2_data_1234", bus.data_o, 16'h1234);
        step();

        wait_idle();
        send(1'b0, 8'hAB);
        wait_idle();
        send(1'b1, 8'hCD);
        bus.clear_i    = 1'b1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'hEE;
        @(negedge clk);
        chk("s4_pre_clear", bus.data_o, 16'hABCD);
        chk("s4_clr_rx_ready", bus.rx_ready_o, 0);
        step();
        bus.clear_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        m_data         = 16'h0000;
        @(negedge clk);
        chk("s4_clr_data", bus.data_o, 16'h0000);
        chk("s4_clr_busy", bus.busy_o, 0);
        step();

        send(1'b1, 8'h55);
        step();
        rst            = 1'b1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h66;
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h77;
        @(negedge clk);
        chk("s5_rst_rx_ready", bus.rx_ready_o, 0);
        chk("s5_rst_tx_ready", bus.tx_ready_o, 0);
        step();
        rst    = 1'b0;
        m_data = 16'h0000;
        expect_xfer(cyc, 1'b0, 8'h66);
        expect_xfer(cyc + 5, 1'b1, 8'h77);
        @(negedge clk);
        chk("s5_rst_data", bus.data_o, 16'h0000);
        chk("s5_rst_src", bus.src_o, 0);
        chk("s5_rst_busy", bus.busy_o, 0);
        step();
        bus.rx_valid_i = 1'b0;
        wait_idle();
        step();
        bus.tx_valid_i = 1'b0;
        wait_idle();
`else
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h01;
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h02;
        expect_xfer(cyc,     1'b0, 8'h01);
        expect_xfer(cyc + 1, 1'b1, 8'h02);
        expect_xfer(cyc + 2, 1'b0, 8'h01);
        expect_xfer(cyc + 3, 1'b1, 8'h02);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nh_busy", bus.busy_o, 0);
            step();
        end
        bus.rx_valid_i = 1'b0;
        bus.tx_valid_i = 1'b0;

        bus.clear_i    = 1'b1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'hEE;
        @(negedge clk);
        chk("nh_pre_clear", bus.data_o, 16'h0102);
        chk("nh_clr_rx_ready", bus.rx_ready_o, 0);
        step();
        bus.clear_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        m_data         = 16'h0000;
        @(negedge clk);
        chk("nh_clr_data", bus.data_o, 16'h0000);
        step();

        send(1'b1, 8'hAA);
        rst = 1'b1;
        step();
        rst    = 1'b0;
        m_data = 16'h0000;
        @(negedge clk);
        chk("nh_rst_data", bus.data_o, 16'h0000);
        chk("nh_rst_src", bus.src_o, 0);
        chk("nh_rst_busy", bus.busy_o, 0);
        step();
`endif
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
